// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one data-memory transaction per
// load/store, formats store lanes, extends load data and stalls the pipe
// until the access has finished.
module mem_stage_lsu #(
    parameter logic [1:0] WB_SEL_MEM = 2'b01,
    parameter int         TIMEOUT    = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_insn_vld,
    input  logic [31:0] i_alu_data,
    input  logic [31:0] i_rs2_data,
    input  logic        i_mem_rw,
    input  logic [2:0]  i_type_access,
    input  logic [1:0]  i_wb_sel,
    input  logic        i_rd_wren,
    output logic        o_stall,
    output logic        o_dmem_req_vld,
    input  logic        i_dmem_req_rdy,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_we,
    output logic [3:0]  o_dmem_wstrb,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_rsp_vld,
    input  logic [31:0] i_dmem_rdata,
    output logic [31:0] o_ld_data,
    output logic        o_rd_wren,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          to_flag;
    logic          timeout_hit;

    // request fields captured at issue so they stay stable while waiting for rdy
    logic [31:0]   r_addr;
    logic          r_we;
    logic [3:0]    r_strb;
    logic [31:0]   r_wdata;
    logic [2:0]    r_type;

    logic          is_mem;
    logic          misal;
    logic [3:0]    fmt_strb;
    logic [31:0]   fmt_wdata;
    logic [31:0]   ext_data;

    assign is_mem = i_insn_vld && (i_mem_rw || (i_wb_sel == WB_SEL_MEM));
    assign misal  = ((i_type_access[1:0] == 2'b01) && i_alu_data[0]) ||
                    ((i_type_access[1:0] == 2'b10) && (i_alu_data[1:0] != 2'b00));
    assign timeout_hit = !i_dmem_rsp_vld && (cnt == CNT_LAST);

    // Store lane replication and byte strobes; loads drive no strobes
    always_comb begin
        fmt_strb  = 4'b0000;
        fmt_wdata = i_rs2_data;
        if (i_mem_rw) begin
            case (i_type_access[1:0])
                2'b00: begin
                    fmt_wdata = {4{i_rs2_data[7:0]}};
                    fmt_strb  = 4'b0001 << i_alu_data[1:0];
                end
                2'b01: begin
                    fmt_wdata = {2{i_rs2_data[15:0]}};
                    fmt_strb  = 4'b0011 << i_alu_data[1:0];
                end
                default: begin
                    fmt_wdata = i_rs2_data;
                    fmt_strb  = 4'b1111;
                end
            endcase
        end
    end

    // Select the addressed byte/half of the read word and extend it
    always_comb begin
        logic [31:0] sh;
        sh       = i_dmem_rdata >> {r_addr[1:0], 3'b000};
        ext_data = i_dmem_rdata;
        case (r_type)
            3'b000:  ext_data = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ext_data = {24'h0, sh[7:0]};
            3'b001:  ext_data = {{16{sh[15]}}, sh[15:0]};
            3'b101:  ext_data = {16'h0, sh[15:0]};
            default: ext_data = i_dmem_rdata;
        endcase
    end

    // Request fields come straight from EX/MEM in IDLE, from the capture afterwards
    assign o_dmem_addr  = (state == IDLE) ? {i_alu_data[31:2], 2'b00} : {r_addr[31:2], 2'b00};
    assign o_dmem_we    = (state == IDLE) ? i_mem_rw  : r_we;
    assign o_dmem_wstrb = (state == IDLE) ? fmt_strb  : r_strb;
    assign o_dmem_wdata = (state == IDLE) ? fmt_wdata : r_wdata;

    // Next-state and control outputs
    always_comb begin
        state_nxt      = state;
        o_dmem_req_vld = 1'b0;
        o_stall        = 1'b0;
        o_rd_wren      = 1'b0;
        o_misaligned   = 1'b0;
        o_bus_err      = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    if (misal) begin
                        o_misaligned = 1'b1;
                    end else begin
                        o_dmem_req_vld = 1'b1;
                        o_stall        = 1'b1;
                        state_nxt      = i_dmem_req_rdy ? RSP : REQ;
                    end
                end else begin
                    o_rd_wren = i_rd_wren;
                end
            end
            REQ: begin
                o_dmem_req_vld = 1'b1;
                o_stall        = 1'b1;
                if (i_dmem_req_rdy) state_nxt = RSP;
            end
            RSP: begin
                o_stall = 1'b1;
                if (i_dmem_rsp_vld || timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                o_rd_wren = i_rd_wren && !to_flag;
                o_bus_err = to_flag;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, capture registers, timeout counter and load result
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            to_flag   <= 1'b0;
            o_ld_data <= 32'h0;
            r_addr    <= 32'h0;
            r_we      <= 1'b0;
            r_strb    <= 4'h0;
            r_wdata   <= 32'h0;
            r_type    <= 3'h0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == RSP) ? cnt + CW'(1) : '0;
            if (state == IDLE && is_mem && !misal) begin
                r_addr  <= i_alu_data;
                r_we    <= i_mem_rw;
                r_strb  <= fmt_strb;
                r_wdata <= fmt_wdata;
                r_type  <= i_type_access;
            end
            if (state == RSP) begin
                to_flag <= timeout_hit;
                if (i_dmem_rsp_vld && !r_we) o_ld_data <= ext_data;
                else if (timeout_hit)        o_ld_data <= 32'h0;
            end else if (state == IDLE) begin
                to_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: aligned loads/stores, backpressure,
// misalignment, timeout and mid-access reset.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        insn_vld;
    logic [31:0] alu_data;
    logic [31:0] rs2_data;
    logic        mem_rw;
    logic [2:0]  type_access;
    logic [1:0]  wb_sel;
    logic        rd_wren_in;
    logic        stall;
    logic        req_vld;
    logic        req_rdy;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        rsp_vld;
    logic [31:0] rdata;
    logic [31:0] ld_data;
    logic        rd_wren;
    logic        misaligned;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    mem_stage_lsu #(.WB_SEL_MEM(2'b01), .TIMEOUT(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_insn_vld(insn_vld), .i_alu_data(alu_data),
        .i_rs2_data(rs2_data), .i_mem_rw(mem_rw), .i_type_access(type_access),
        .i_wb_sel(wb_sel), .i_rd_wren(rd_wren_in), .o_stall(stall),
        .o_dmem_req_vld(req_vld), .i_dmem_req_rdy(req_rdy), .o_dmem_addr(dmem_addr),
        .o_dmem_we(dmem_we), .o_dmem_wstrb(dmem_wstrb), .o_dmem_wdata(dmem_wdata),
        .i_dmem_rsp_vld(rsp_vld), .i_dmem_rdata(rdata), .o_ld_data(ld_data),
        .o_rd_wren(rd_wren), .o_misaligned(misaligned), .o_bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_insn(input logic v, input logic rw, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] d, input logic rdw);
        insn_vld    = v;
        mem_rw      = rw;
        type_access = t;
        alu_data    = a;
        rs2_data    = d;
        wb_sel      = rw ? 2'b00 : 2'b01;
        rd_wren_in  = rdw;
    endtask

    // rdy=1 on issue, response one cycle later
    task automatic mem_op(input string tag, input logic rw, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                          input logic [31:0] exp_ld, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input logic rdw);
        cyc();
        set_insn(1'b1, rw, t, a, d, rdw);
        req_rdy = 1'b1;
        #1;
        chk({tag, ".req_vld"}, 32'(req_vld), 32'd1);
        chk({tag, ".stall0"}, 32'(stall), 32'd1);
        chk({tag, ".addr"}, dmem_addr, {a[31:2], 2'b00});
        chk({tag, ".we"}, 32'(dmem_we), 32'(rw));
        chk({tag, ".strb"}, 32'(dmem_wstrb), 32'(exp_strb));
        if (rw) chk({tag, ".wdata"}, dmem_wdata, exp_wdata);
        cyc();
        req_rdy = 1'b0;
        rsp_vld = 1'b1;
        rdata   = rd;
        #1;
        chk({tag, ".stall1"}, 32'(stall), 32'd1);
        chk({tag, ".req_drop"}, 32'(req_vld), 32'd0);
        cyc();
        rsp_vld = 1'b0;
        #1;
        chk({tag, ".done_stall"}, 32'(stall), 32'd0);
        if (!rw) chk({tag, ".ld"}, ld_data, exp_ld);
        chk({tag, ".rd_wren"}, 32'(rd_wren), 32'(rdw));
        cyc();
        insn_vld = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_insn(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
        req_rdy = 1'b0;
        rsp_vld = 1'b0;
        rdata   = 32'h0;
        repeat (2) cyc();
        reset = 1'b0;
        #1;
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.req_vld", 32'(req_vld), 32'd0);
        chk("rst.ld", ld_data, 32'h0);
        chk("rst.bus_err", 32'(bus_err), 32'd0);
        chk("rst.misal", 32'(misaligned), 32'd0);

        // non-memory instruction passes straight through
        cyc();
        insn_vld = 1'b1; wb_sel = 2'b00; rd_wren_in = 1'b1;
        #1;
        chk("alu.stall", 32'(stall), 32'd0);
        chk("alu.req", 32'(req_vld), 32'd0);
        chk("alu.rd_wren", 32'(rd_wren), 32'd1);

        mem_op("lw",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 32'h0, 1'b1);
        mem_op("lb",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 32'hFFFFFF80, 4'h0, 32'h0, 1'b1);
        mem_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 32'h00000080, 4'h0, 32'h0, 1'b1);
        mem_op("lh",  1'b0, 3'b001, 32'h102, 32'h0, 32'h80FFFF7F, 32'hFFFF80FF, 4'h0, 32'h0, 1'b1);
        mem_op("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FFFF7F, 32'h0000FF7F, 4'h0, 32'h0, 1'b1);
        mem_op("lb0", 1'b0, 3'b000, 32'h101, 32'h0, 32'h80FFFF7F, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b1);
        mem_op("sb",  1'b1, 3'b000, 32'h202, 32'h12345678, 32'h0, 32'h0, 4'b0100, 32'h78787878, 1'b0);
        mem_op("sh",  1'b1, 3'b001, 32'h202, 32'h12345678, 32'h0, 32'h0, 4'b1100, 32'h56785678, 1'b0);
        mem_op("sw",  1'b1, 3'b010, 32'h204, 32'hA5A5C3C3, 32'h0, 32'h0, 4'b1111, 32'hA5A5C3C3, 1'b0);

        // backpressure: rdy low for 3 cycles, EX/MEM inputs disturbed, spurious rsp ignored
        cyc();
        set_insn(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1'b1);
        req_rdy = 1'b0;
        #1;
        chk("bp.idle.req", 32'(req_vld), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            alu_data = 32'h0000_0F08;
            rsp_vld  = (i == 0);
            rdata    = 32'h11111111;
            req_rdy  = (i == 2);
            #1;
            chk("bp.req_vld", 32'(req_vld), 32'd1);
            chk("bp.stall", 32'(stall), 32'd1);
            chk("bp.addr", dmem_addr, 32'h104);
            chk("bp.we", 32'(dmem_we), 32'd0);
        end
        cyc();
        alu_data = 32'h104;
        req_rdy  = 1'b0;
        rsp_vld  = 1'b1;
        rdata    = 32'hCAFEF00D;
        #1;
        chk("bp.rsp.stall", 32'(stall), 32'd1);
        cyc();
        rsp_vld = 1'b0;
        #1;
        chk("bp.done.stall", 32'(stall), 32'd0);
        chk("bp.ld", ld_data, 32'hCAFEF00D);
        cyc();
        insn_vld = 1'b0;

        // misaligned word load
        cyc();
        set_insn(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1'b1);
        req_rdy = 1'b1;
        #1;
        chk("mis.flag", 32'(misaligned), 32'd1);
        chk("mis.req", 32'(req_vld), 32'd0);
        chk("mis.stall", 32'(stall), 32'd0);
        chk("mis.rd_wren", 32'(rd_wren), 32'd0);
        cyc();
        set_insn(1'b1, 1'b1, 3'b001, 32'h203, 32'h0, 1'b0);
        #1;
        chk("mis.sh", 32'(misaligned), 32'd1);
        chk("mis.sh.req", 32'(req_vld), 32'd0);
        cyc();
        insn_vld = 1'b0;
        req_rdy  = 1'b0;

        // timeout: no response for TIMEOUT=4 RSP cycles
        cyc();
        set_insn(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1);
        req_rdy = 1'b1;
        #1;
        chk("to.req", 32'(req_vld), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            req_rdy = 1'b0;
            #1;
            chk("to.stall", 32'(stall), 32'd1);
            chk("to.noerr", 32'(bus_err), 32'd0);
        end
        cyc();
        #1;
        chk("to.bus_err", 32'(bus_err), 32'd1);
        chk("to.ld", ld_data, 32'h0);
        chk("to.rd_wren", 32'(rd_wren), 32'd0);
        chk("to.done.stall", 32'(stall), 32'd0);
        cyc();
        insn_vld = 1'b0;
        #1;
        chk("to.err_pulse", 32'(bus_err), 32'd0);

        // reset during RSP
        mem_op("lw2", 1'b0, 3'b010, 32'h108, 32'h0, 32'h01234567, 32'h01234567, 4'h0, 32'h0, 1'b1);
        cyc();
        set_insn(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 1'b1);
        req_rdy = 1'b1;
        cyc();
        req_rdy  = 1'b0;
        reset    = 1'b1;
        insn_vld = 1'b0;
        #1;
        chk("rr.rsp.stall", 32'(stall), 32'd1);
        cyc();
        reset   = 1'b0;
        rsp_vld = 1'b1;
        rdata   = 32'h55AA55AA;
        #1;
        chk("rr.stall", 32'(stall), 32'd0);
        chk("rr.req", 32'(req_vld), 32'd0);
        chk("rr.ld", ld_data, 32'h0);
        cyc();
        rsp_vld = 1'b0;
        #1;
        chk("rr.ld_ignored", ld_data, 32'h0);
        chk("rr.bus_err", 32'(bus_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
